// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable word RAM plus MMIO block (LED, TIMER,
// SCRATCH, 4-entry TX FIFO). Ports: clk, reset, data_sram_* request/rdata,
// led, tx_valid/tx_data/tx_ready drain port.
module data_sram_responder #(
   parameter int          RAM_AW  = 12,
   parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   logic [31:0] r_mem [2**RAM_AW];
   logic [15:0] r_led;
   logic [31:0] r_tm;
   logic [31:0] r_scr;
   logic [7:0]  r_fifo [4];
   logic [1:0]  r_wp;
   logic [1:0]  r_rp;
   logic [2:0]  r_cnt;
   logic        r_ovf;
   logic [31:0] r_rdata;

   logic              w_mmio;
   logic [13:0]       w_off;
   logic [RAM_AW-1:0] w_idx;
   logic              w_wr;
   logic              w_ram_wr;
   logic              w_led_wr;
   logic              w_tm_wr;
   logic              w_scr_wr;
   logic              w_st_clr;
   logic              w_push;
   logic              w_push_ok;
   logic              w_pop;
   logic              w_full;
   logic [31:0]       w_status;
   logic [31:0]       w_mmio_rd;
   logic              w_unused;

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] w,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = w[8*i +: 8];
      return r;
   endfunction

   // Word offsets only; the byte lane bits take no part in decode.
   assign w_unused = ^data_sram_addr[1:0];
   assign w_mmio   = data_sram_addr[31:16] == MMIO_HI;
   assign w_off    = data_sram_addr[15:2];
   assign w_idx    = data_sram_addr[RAM_AW+1:2];
   assign w_wr     = data_sram_en & (|data_sram_we);
   assign w_ram_wr = w_wr & ~w_mmio;
   assign w_led_wr = w_wr & w_mmio & (w_off == 14'h0000);
   assign w_tm_wr  = w_wr & w_mmio & (w_off == 14'h0001);
   assign w_scr_wr = w_wr & w_mmio & (w_off == 14'h0002);
   assign w_st_clr = w_wr & w_mmio & (w_off == 14'h0005);
   assign w_push   = data_sram_en & data_sram_we[0] & w_mmio
                   & (w_off == 14'h0004);

   // FIFO status comes only from registers: no input-to-tx_valid path.
   assign tx_valid  = r_cnt != 3'd0;
   assign tx_data   = tx_valid ? r_fifo[r_rp] : 8'h00;
   assign w_full    = r_cnt == 3'd4;
   assign w_pop     = tx_valid & tx_ready;
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_status  = {16'h0, 5'h0, r_cnt, 5'h0, r_ovf, ~tx_valid, w_full};

   always_comb begin
      w_mmio_rd = 32'h0;
      case (w_off)
         14'h0000: w_mmio_rd = {16'h0, r_led};
         14'h0001: w_mmio_rd = r_tm;
         14'h0002: w_mmio_rd = r_scr;
         14'h0005: w_mmio_rd = w_status;
         default:  w_mmio_rd = 32'h0;
      endcase
   end

   // RAM array carries no reset; writes are suppressed while in reset.
   always_ff @(posedge clk) begin
      if (w_ram_wr && !reset)
         for (int i = 0; i < 4; i++)
            if (data_sram_we[i])
               r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= 32'h0;
         r_led   <= 16'h0;
         r_tm    <= 32'h0;
         r_scr   <= 32'h0;
         r_wp    <= 2'd0;
         r_rp    <= 2'd0;
         r_cnt   <= 3'd0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < 4; i++) r_fifo[i] <= 8'h00;
      end else begin
         // Read-first: old RAM word / pre-edge register value.
         if (data_sram_en)
            r_rdata <= w_mmio ? w_mmio_rd : r_mem[w_idx];
         if (w_led_wr)
            r_led <= merge({16'h0, r_led}, data_sram_wdata,
                           data_sram_we) [15:0];
         r_tm <= w_tm_wr ? merge(r_tm, data_sram_wdata, data_sram_we)
                         : r_tm + 32'd1;
         if (w_scr_wr)
            r_scr <= merge(r_scr, data_sram_wdata, data_sram_we);
         if (w_push_ok) begin
            r_fifo[r_wp] <= data_sram_wdata[7:0];
            r_wp         <= r_wp + 2'd1;
         end
         if (w_pop)
            r_rp <= r_rp + 2'd1;
         case ({w_push_ok, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_st_clr)
            r_ovf <= 1'b0;
         else if (w_push & w_full & ~w_pop)
            r_ovf <= 1'b1;
      end
   end

   assign data_sram_rdata = r_rdata;
   assign led             = r_led;

endmodule
